// File: rtl/cpu_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_cache : direct-mapped write-back / write-allocate cache, single-line miss FSM
// Revision  : 1.0
// ---------------------------------------------------------------------------
module cpu_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int NUM_LINES  = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  cache_req_read_i,
  input  logic                  cache_req_write_i,
  input  logic [ADDR_WIDTH-1:0] cache_req_addr_i,
  input  logic [WORD_WIDTH-1:0] cache_req_data_i,
  output logic                  cache_rsp_hit_o,
  output logic [WORD_WIDTH-1:0] cache_rsp_data_o,
  output logic                  mem_req_read_o,
  output logic                  mem_req_write_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [LINE_WIDTH-1:0] mem_req_data_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [ADDR_WIDTH-1:0] mem_rsp_addr_i,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data_i
);

  localparam int BYTE_W = $clog2(WORD_WIDTH / 8);
  localparam int WSEL_W = $clog2(LINE_WIDTH / WORD_WIDTH);
  localparam int OFF_W  = BYTE_W + WSEL_W;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FILL} state_e;

  state_e                state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [LINE_WIDTH-1:0] line_q [NUM_LINES];
  logic [IDX_W-1:0]      idx_q;
  logic [TAG_W-1:0]      miss_tag_q;

  logic [WSEL_W-1:0]     req_wsel;
  logic [IDX_W-1:0]      req_idx, line_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag;
  logic [ADDR_WIDTH-1:0] wb_addr, fill_addr;
  logic                  req, lookup_hit;
  logic                  do_write_hit, do_fill, do_wb_done, do_capture;
  logic                  unused_ok;

  assign req_wsel  = cache_req_addr_i[OFF_W-1:BYTE_W];
  assign req_idx   = cache_req_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign req_tag   = cache_req_addr_i[ADDR_WIDTH-1:OFF_W+IDX_W];
  assign unused_ok = ^cache_req_addr_i[BYTE_W-1:0];

  assign req        = cache_req_read_i | cache_req_write_i;
  assign lookup_hit = req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // In IDLE the miss is resolved from the live request; afterwards from the captured one
  assign line_idx  = (state_q == S_IDLE) ? req_idx : idx_q;
  assign fill_tag  = (state_q == S_IDLE) ? req_tag : miss_tag_q;
  assign wb_addr   = {tag_q[line_idx], line_idx, {OFF_W{1'b0}}};
  assign fill_addr = {fill_tag, line_idx, {OFF_W{1'b0}}};

  always_comb begin
    state_d          = state_q;
    cache_rsp_hit_o  = 1'b0;
    cache_rsp_data_o = '0;
    mem_req_read_o   = 1'b0;
    mem_req_write_o  = 1'b0;
    mem_req_addr_o   = '0;
    mem_req_data_o   = '0;
    do_write_hit     = 1'b0;
    do_fill          = 1'b0;
    do_wb_done       = 1'b0;
    do_capture       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lookup_hit) begin
          cache_rsp_hit_o = 1'b1;
          if (cache_req_write_i) begin
            do_write_hit = 1'b1;
          end else begin
            cache_rsp_data_o = line_q[req_idx][req_wsel*WORD_WIDTH +: WORD_WIDTH];
          end
        end else if (req) begin
          do_capture = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            mem_req_write_o = 1'b1;
            mem_req_addr_o  = wb_addr;
            mem_req_data_o  = line_q[req_idx];
            state_d         = S_WRITEBACK;
          end else begin
            mem_req_read_o = 1'b1;
            mem_req_addr_o = fill_addr;
            state_d        = S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        mem_req_write_o = 1'b1;
        mem_req_addr_o  = wb_addr;
        mem_req_data_o  = line_q[idx_q];
        if (mem_rsp_valid_i && (mem_rsp_addr_i == wb_addr)) begin
          do_wb_done = 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        mem_req_read_o = 1'b1;
        mem_req_addr_o = fill_addr;
        if (mem_rsp_valid_i && (mem_rsp_addr_i == fill_addr)) begin
          do_fill = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset_i) begin
      state_d          = S_IDLE;
      cache_rsp_hit_o  = 1'b0;
      cache_rsp_data_o = '0;
      mem_req_read_o   = 1'b0;
      mem_req_write_o  = 1'b0;
      mem_req_addr_o   = '0;
      mem_req_data_o   = '0;
      do_write_hit     = 1'b0;
      do_fill          = 1'b0;
      do_wb_done       = 1'b0;
      do_capture       = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (do_write_hit) dirty_q[req_idx] <= 1'b1;
      if (do_wb_done)   dirty_q[idx_q]   <= 1'b0;
      if (do_fill) begin
        valid_q[idx_q] <= 1'b1;
        dirty_q[idx_q] <= 1'b0;
      end
    end
  end

  // Storage and miss bookkeeping need no reset: valid bits qualify every use
  always_ff @(posedge clock_i) begin
    if (do_capture) begin
      idx_q      <= req_idx;
      miss_tag_q <= req_tag;
    end
    if (do_write_hit) line_q[req_idx][req_wsel*WORD_WIDTH +: WORD_WIDTH] <= cache_req_data_i;
    if (do_fill) begin
      line_q[idx_q] <= mem_rsp_data_i;
      tag_q[idx_q]  <= miss_tag_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_cache : directed vector bench for cpu_cache
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_cpu_cache;

  localparam logic [127:0] L0 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L2 = 128'h99999999_88888888_77777777_66666666;
  localparam logic [127:0] WB0 = 128'hDDDDDDDD_CCCCCCCC_12345678_AAAAAAAA;
  localparam logic [127:0] WB1 = 128'h44444444_33333333_CAFEF00D_11111111;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  typedef struct {
    logic         rst, rd, wr;
    logic [31:0]  addr, wdata;
    logic         mv;
    logic [31:0]  maddr;
    logic [127:0] mdata;
    logic         ehit;
    logic [31:0]  edata;
    logic         emrd, emwr;
    logic [31:0]  emaddr;
    logic [127:0] emdata;
  } vec_t;

  logic         clk, reset;
  logic         rd, wr, mv;
  logic [31:0]  addr, wdata, maddr;
  logic [127:0] mdata;
  logic         hit, mrd, mwr;
  logic [31:0]  rdata, mreq_addr;
  logic [127:0] mreq_data;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  cpu_cache dut (
    .clock_i          (clk),
    .reset_i          (reset),
    .cache_req_read_i (rd),
    .cache_req_write_i(wr),
    .cache_req_addr_i (addr),
    .cache_req_data_i (wdata),
    .cache_rsp_hit_o  (hit),
    .cache_rsp_data_o (rdata),
    .mem_req_read_o   (mrd),
    .mem_req_write_o  (mwr),
    .mem_req_addr_o   (mreq_addr),
    .mem_req_data_o   (mreq_data),
    .mem_rsp_valid_i  (mv),
    .mem_rsp_addr_i   (maddr),
    .mem_rsp_data_i   (mdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic a_rd, input logic a_wr,
                              input logic [31:0] a_addr, input logic [31:0] a_wdata,
                              input logic a_mv, input logic [31:0] a_maddr, input logic [127:0] a_mdata,
                              input logic e_hit, input logic [31:0] e_data,
                              input logic e_mrd, input logic e_mwr,
                              input logic [31:0] e_maddr, input logic [127:0] e_mdata);
    vec_t v;
    v.rst = r; v.rd = a_rd; v.wr = a_wr; v.addr = a_addr; v.wdata = a_wdata;
    v.mv = a_mv; v.maddr = a_maddr; v.mdata = a_mdata;
    v.ehit = e_hit; v.edata = e_data; v.emrd = e_mrd; v.emwr = e_mwr;
    v.emaddr = e_maddr; v.emdata = e_mdata;
    return v;
  endfunction

  task automatic check(input string name, input int id, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, id, act, exp);
    end
  endtask

  // Drive one cycle of stimulus after the edge, check combinational outputs mid-cycle
  task automatic apply(input vec_t v, input int id);
    @(posedge clk);
    #1;
    reset = v.rst; rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata;
    mv = v.mv; maddr = v.maddr; mdata = v.mdata;
    @(negedge clk);
    check("hit", id, {127'd0, hit}, {127'd0, v.ehit});
    check("rdata", id, {96'd0, rdata}, {96'd0, v.edata});
    check("mem_read", id, {127'd0, mrd}, {127'd0, v.emrd});
    check("mem_write", id, {127'd0, mwr}, {127'd0, v.emwr});
    if (v.emrd || v.emwr) check("mem_addr", id, {96'd0, mreq_addr}, {96'd0, v.emaddr});
    if (v.emwr) check("mem_data", id, mreq_data, v.emdata);
  endtask

  initial begin
    //                 rst rd wr addr         wdata         mv maddr        mdata  hit edata         mrd mwr emaddr       emdata
    tbl.push_back(mk(N, Y, N, 32'h00, 32'h0,        N, 32'h00, '0, N, 32'h0,        Y, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h00, 32'h0,        N, 32'h00, '0, N, 32'h0,        Y, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h00, 32'h0,        Y, 32'h00, L0, N, 32'h0,        Y, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h00, 32'h0,        N, 32'h00, '0, Y, 32'hAAAAAAAA, N, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h04, 32'h0,        N, 32'h00, '0, Y, 32'hBBBBBBBB, N, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h08, 32'h0,        N, 32'h00, '0, Y, 32'hCCCCCCCC, N, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h0C, 32'h0,        N, 32'h00, '0, Y, 32'hDDDDDDDD, N, N, 32'h00, '0));
    tbl.push_back(mk(N, N, Y, 32'h04, 32'h12345678, N, 32'h00, '0, Y, 32'h0,        N, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h04, 32'h0,        N, 32'h00, '0, Y, 32'h12345678, N, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h40, 32'h0,        N, 32'h00, '0, N, 32'h0,        N, Y, 32'h00, WB0));
    tbl.push_back(mk(N, Y, N, 32'h40, 32'h0,        Y, 32'h80, L2, N, 32'h0,        N, Y, 32'h00, WB0));
    tbl.push_back(mk(N, Y, N, 32'h40, 32'h0,        Y, 32'h00, '0, N, 32'h0,        N, Y, 32'h00, WB0));
    tbl.push_back(mk(N, Y, N, 32'h40, 32'h0,        N, 32'h00, '0, N, 32'h0,        Y, N, 32'h40, '0));
    tbl.push_back(mk(N, Y, N, 32'h40, 32'h0,        Y, 32'h80, L2, N, 32'h0,        Y, N, 32'h40, '0));
    tbl.push_back(mk(N, Y, N, 32'h40, 32'h0,        Y, 32'h40, L1, N, 32'h0,        Y, N, 32'h40, '0));
    tbl.push_back(mk(N, Y, N, 32'h40, 32'h0,        N, 32'h00, '0, Y, 32'h11111111, N, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, Y, 32'h44, 32'hCAFEF00D, N, 32'h00, '0, Y, 32'h0,        N, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h44, 32'h0,        N, 32'h00, '0, Y, 32'hCAFEF00D, N, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h00, 32'h0,        N, 32'h00, '0, N, 32'h0,        N, Y, 32'h40, WB1));
    tbl.push_back(mk(N, Y, N, 32'h10, 32'h0,        N, 32'h00, '0, N, 32'h0,        N, Y, 32'h40, WB1));
    tbl.push_back(mk(N, Y, N, 32'h10, 32'h0,        Y, 32'h40, '0, N, 32'h0,        N, Y, 32'h40, WB1));
    tbl.push_back(mk(N, Y, N, 32'h10, 32'h0,        N, 32'h00, '0, N, 32'h0,        Y, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h10, 32'h0,        Y, 32'h00, L0, N, 32'h0,        Y, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h10, 32'h0,        N, 32'h00, '0, N, 32'h0,        Y, N, 32'h10, '0));
    tbl.push_back(mk(Y, Y, N, 32'h10, 32'h0,        N, 32'h00, '0, N, 32'h0,        N, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h00, 32'h0,        Y, 32'h10, L1, N, 32'h0,        Y, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h00, 32'h0,        Y, 32'h10, L1, N, 32'h0,        Y, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h00, 32'h0,        Y, 32'h00, L0, N, 32'h0,        Y, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h00, 32'h0,        N, 32'h00, '0, Y, 32'hAAAAAAAA, N, N, 32'h00, '0));
    tbl.push_back(mk(N, Y, N, 32'h10, 32'h0,        N, 32'h00, '0, N, 32'h0,        Y, N, 32'h10, '0));
    tbl.push_back(mk(N, Y, N, 32'h10, 32'h0,        Y, 32'h10, L1, N, 32'h0,        Y, N, 32'h10, '0));
    tbl.push_back(mk(N, Y, N, 32'h14, 32'h0,        N, 32'h00, '0, Y, 32'h22222222, N, N, 32'h00, '0));

    reset = 1'b1; rd = 1'b1; wr = 1'b0; addr = '0; wdata = '0;
    mv = 1'b0; maddr = '0; mdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hit", -1, {127'd0, hit}, 128'd0);
    check("reset_mem_read", -1, {127'd0, mrd}, 128'd0);
    check("reset_mem_write", -1, {127'd0, mwr}, 128'd0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Write miss allocates, then the held write merges into the filled line
    apply(mk(N, N, Y, 32'h28, 32'h0000BEEF, N, 32'h00, '0, N, 32'h0,        Y, N, 32'h20, '0), 100);
    apply(mk(N, N, Y, 32'h28, 32'h0000BEEF, Y, 32'h20, L2, N, 32'h0,        Y, N, 32'h20, '0), 101);
    apply(mk(N, N, Y, 32'h28, 32'h0000BEEF, N, 32'h00, '0, Y, 32'h0,        N, N, 32'h00, '0), 102);
    apply(mk(N, Y, N, 32'h28, 32'h0,        N, 32'h00, '0, Y, 32'h0000BEEF, N, N, 32'h00, '0), 103);
    apply(mk(N, Y, N, 32'h24, 32'h0,        N, 32'h00, '0, Y, 32'h77777777, N, N, 32'h00, '0), 104);
    apply(mk(N, Y, N, 32'h23, 32'h0,        N, 32'h00, '0, Y, 32'h66666666, N, N, 32'h00, '0), 105);
    // Idle with no request: no memory traffic
    apply(mk(N, N, N, 32'h40, 32'h0,        N, 32'h00, '0, N, 32'h0,        N, N, 32'h00, '0), 106);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_cache.md
CPU_CACHE -- requirements
Module: cpu_cache

Interface
REQ-001 SHALL: ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL: WORD_WIDTH, default 32, CPU word width.
REQ-003 SHALL: LINE_WIDTH, default 128, cache line width (4 words).
REQ-004 SHALL: NUM_LINES, default 4, number of direct-mapped lines.
REQ-005 SHALL: one clock; reset is synchronous and active-high.
REQ-006 SHALL: clock  in  1  rising-edge clock.
REQ-007 SHALL: reset  in  1  synchronous active-high reset.
REQ-008 SHALL: cache_request_if.read/.write  in  1 each  CPU read / write request (level, held until hit).
REQ-009 SHALL: cache_request_if.addr  in  ADDR_WIDTH  byte address; cache_request_if.data  in  WORD_WIDTH  write data.
REQ-010 SHALL: cache_response_if.hit  out  1  request satisfied this cycle; cache_response_if.data  out  WORD_WIDTH  read data.
REQ-011 SHALL: mem_request_if.read/.write  out  1 each  line fill / line writeback request.
REQ-012 SHALL: mem_request_if.addr  out  ADDR_WIDTH  line-aligned address (addr[3:0]=0); mem_request_if.data  out  LINE_WIDTH  writeback line.
REQ-013 SHALL: mem_response_if.valid  in  1  memory response strobe; mem_response_if.addr  in  ADDR_WIDTH  echoed line address; mem_response_if.data  in  LINE_WIDTH  fill line.

Function
REQ-014 SHALL: address split: addr[1:0] ignored, addr[3:2] word select, addr[5:4] index, addr[31:6] tag.
REQ-015 SHALL: word n of a line is line[32n+31:32n] (word 0 = bits 31:0).
REQ-016 SHALL: each line holds valid, dirty, tag, 128-bit data; direct mapped; write-back, write-allocate.
REQ-017 SHALL: lookup is combinational: hit=1 when (read or write) and line[index] valid and tag equal, in the same cycle; data = selected word on read hit, else 0.
REQ-018 SHALL: write hit updates selected word and sets dirty at the rising edge of the hit cycle.
REQ-019 SHALL: read and write both asserted is treated as write.
REQ-020 SHALL: FSM states IDLE, WRITEBACK, FILL; miss in IDLE with victim clean -> FILL, victim valid and dirty -> WRITEBACK.
REQ-021 SHALL: on miss, mem request is driven combinationally in the miss cycle (Mealy): FILL-bound drives read=1, addr={tag,index,4'b0}; WRITEBACK-bound drives write=1, addr={victim tag,index,4'b0}, data=victim line.
REQ-022 SHALL: WRITEBACK holds mem write/addr/data until valid=1 with mem_response_if.addr equal to the victim address; then dirty cleared and FSM moves to FILL.
REQ-023 SHALL: FILL holds mem read/addr until valid=1 with matching addr; at that edge line is written with response data, valid=1, dirty=0, tag updated; FSM returns to IDLE.
REQ-024 SHALL: response with non-matching addr or valid=0 is ignored; no timeout.
REQ-025 SHALL: after fill the still-held request hits in the next cycle (read hit data, or write merged per REQ-018); miss-to-hit latency = 1 cycle after response edge.
REQ-026 SHALL: request change during WRITEBACK/FILL does not abort the transaction; the new address is evaluated on return to IDLE.
REQ-027 SHALL: mem_request read and write never both 1; both 0 in IDLE without miss.

Reset
REQ-028 SHALL: reset clears all valid and dirty bits, FSM=IDLE; mem read/write=0, hit=0 while reset is high; data contents are don't-care.
REQ-029 SHALL: reset asserted during WRITEBACK/FILL aborts the transaction; a later response is ignored.

Verification
REQ-030 SHALL: after reset, read addr 0x0 -> hit=0, mem read=1, mem addr=0x0, same cycle.
REQ-031 SHALL: then valid=1, addr=0x0, data=128'hDDDDDDDDCCCCCCCCBBBBBBBBAAAAAAAA for one edge -> next cycle hit=1, data=AAAAAAAA, mem read=0.
REQ-032 SHALL: subsequent reads 0x4, 0x8, 0xC -> hit=1 each cycle, data BBBBBBBB, CCCCCCCC, DDDDDDDD, no mem request.
REQ-033 SHALL: write 0x4=0x12345678 (hit), then read 0x4 -> 12345678; read 0x40 (same index) -> mem write=1, addr=0x0, data=DDDDDDDDCCCCCCCC12345678AAAAAAAA.
REQ-034 SHALL: ack writeback (valid, addr 0x0) -> mem read=1 addr 0x40; response with addr 0x80 ignored; matching fill -> hit next cycle.
REQ-035 SHALL: reset mid-FILL -> mem read=0, read 0x0 misses again afterwards.
